// File: rtl/lcd_8080_rx.sv
// Panel-side responder for the 8080-style parallel LCD bus: samples the async bus,
// decodes an ILI9341-like command subset and emits a clipped pixel stream.
module lcd_8080_rx #(
  parameter int H_RES = 240,
  parameter int V_RES = 320
) (
  input  logic        clk,
  input  logic        RSTn,
  input  logic        LCD_CS,
  input  logic        LCD_RS,
  input  logic        LCD_WR,
  input  logic        LCD_RD,
  input  logic        LCD_RST,
  input  logic [15:0] LCD_DATA,
  output logic [15:0] LCD_DATA_OUT,
  output logic        LCD_DATA_OE,
  output logic        pix_valid,
  output logic [15:0] pix_x,
  output logic [15:0] pix_y,
  output logic [15:0] pix_data,
  output logic        disp_on,
  output logic        cmd_err
);

  typedef enum logic [2:0] {
    IDLE,
    PARAM_CA,
    PARAM_PA,
    MEM_WRITE,
    READ_PM
  } state_t;

  localparam logic [15:0] EC_RST = 16'(H_RES - 1);
  localparam logic [15:0] EP_RST = 16'(V_RES - 1);

  // Two-stage synchronisers; strobes idle high so they reset to 1
  logic        cs_s1_reg, cs_s2_reg, rs_s1_reg, rs_s2_reg;
  logic        wr_s1_reg, wr_s2_reg, wr_d_reg;
  logic        rd_s1_reg, rd_s2_reg, rd_d_reg;
  logic        rst_s1_reg, rst_s2_reg;
  logic [15:0] data_s1_reg, data_s2_reg;

  state_t      state_reg, state_next;
  logic [15:0] sc_reg, sc_next, ec_reg, ec_next;
  logic [15:0] sp_reg, sp_next, ep_reg, ep_next;
  logic [15:0] px_reg, px_next, py_reg, py_next;
  logic [1:0]  byte_cnt_reg, byte_cnt_next;
  logic [7:0]  rd_idx_reg, rd_idx_next;
  logic        disp_on_reg, disp_on_next;
  logic        pix_valid_reg, pix_valid_next;
  logic [15:0] pix_x_reg, pix_x_next, pix_y_reg, pix_y_next;
  logic [15:0] pix_data_reg, pix_data_next;
  logic        cmd_err_reg, cmd_err_next;
  logic        oe_reg, oe_next;
  logic [15:0] data_out_reg, data_out_next;

  logic wr_evt, rd_act, rd_rise, win_ok, soft_rst;

  assign wr_evt  = ~cs_s2_reg & ~wr_d_reg & wr_s2_reg;
  assign rd_act  = ~cs_s2_reg & ~rd_s2_reg;
  assign rd_rise = ~cs_s2_reg & ~rd_d_reg & rd_s2_reg;
  assign win_ok  = (sc_reg <= ec_reg) && (sp_reg <= ep_reg);

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      cs_s1_reg   <= 1'b1;  cs_s2_reg  <= 1'b1;
      rs_s1_reg   <= 1'b0;  rs_s2_reg  <= 1'b0;
      wr_s1_reg   <= 1'b1;  wr_s2_reg  <= 1'b1;  wr_d_reg <= 1'b1;
      rd_s1_reg   <= 1'b1;  rd_s2_reg  <= 1'b1;  rd_d_reg <= 1'b1;
      rst_s1_reg  <= 1'b1;  rst_s2_reg <= 1'b1;
      data_s1_reg <= 16'h0000;
      data_s2_reg <= 16'h0000;
    end else begin
      cs_s1_reg   <= LCD_CS;      cs_s2_reg   <= cs_s1_reg;
      rs_s1_reg   <= LCD_RS;      rs_s2_reg   <= rs_s1_reg;
      wr_s1_reg   <= LCD_WR;      wr_s2_reg   <= wr_s1_reg;  wr_d_reg <= wr_s2_reg;
      rd_s1_reg   <= LCD_RD;      rd_s2_reg   <= rd_s1_reg;  rd_d_reg <= rd_s2_reg;
      rst_s1_reg  <= LCD_RST;     rst_s2_reg  <= rst_s1_reg;
      data_s1_reg <= LCD_DATA;    data_s2_reg <= data_s1_reg;
    end
  end

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      state_reg     <= IDLE;
      sc_reg        <= 16'h0000;
      ec_reg        <= EC_RST;
      sp_reg        <= 16'h0000;
      ep_reg        <= EP_RST;
      px_reg        <= 16'h0000;
      py_reg        <= 16'h0000;
      byte_cnt_reg  <= 2'd0;
      rd_idx_reg    <= 8'd0;
      disp_on_reg   <= 1'b0;
      pix_valid_reg <= 1'b0;
      pix_x_reg     <= 16'h0000;
      pix_y_reg     <= 16'h0000;
      pix_data_reg  <= 16'h0000;
      cmd_err_reg   <= 1'b0;
      oe_reg        <= 1'b0;
      data_out_reg  <= 16'h0000;
    end else begin
      state_reg     <= state_next;
      sc_reg        <= sc_next;
      ec_reg        <= ec_next;
      sp_reg        <= sp_next;
      ep_reg        <= ep_next;
      px_reg        <= px_next;
      py_reg        <= py_next;
      byte_cnt_reg  <= byte_cnt_next;
      rd_idx_reg    <= rd_idx_next;
      disp_on_reg   <= disp_on_next;
      pix_valid_reg <= pix_valid_next;
      pix_x_reg     <= pix_x_next;
      pix_y_reg     <= pix_y_next;
      pix_data_reg  <= pix_data_next;
      cmd_err_reg   <= cmd_err_next;
      oe_reg        <= oe_next;
      data_out_reg  <= data_out_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    sc_next        = sc_reg;
    ec_next        = ec_reg;
    sp_next        = sp_reg;
    ep_next        = ep_reg;
    px_next        = px_reg;
    py_next        = py_reg;
    byte_cnt_next  = byte_cnt_reg;
    rd_idx_next    = rd_idx_reg;
    disp_on_next   = disp_on_reg;
    pix_valid_next = 1'b0;
    pix_x_next     = pix_x_reg;
    pix_y_next     = pix_y_reg;
    pix_data_next  = pix_data_reg;
    cmd_err_next   = 1'b0;
    soft_rst       = 1'b0;
    // A concurrent write strobe wins over a read: never drive the bus then
    oe_next        = rd_act & wr_s2_reg;
    data_out_next  = 16'h0000;

    if (rd_act && wr_s2_reg && state_reg == READ_PM && rd_idx_reg != 8'd0)
      data_out_next = {13'b0, disp_on_reg, 2'b00};
    if (rd_rise && rd_idx_reg != 8'hFF)
      rd_idx_next = rd_idx_reg + 8'd1;

    if (wr_evt) begin
      if (!rs_s2_reg) begin
        case (data_s2_reg[7:0])
          8'h2A: begin state_next = PARAM_CA; byte_cnt_next = 2'd0; end
          8'h2B: begin state_next = PARAM_PA; byte_cnt_next = 2'd0; end
          8'h2C: begin state_next = MEM_WRITE; px_next = sc_reg; py_next = sp_reg; end
          8'h28: begin disp_on_next = 1'b0; state_next = IDLE; end
          8'h29: begin disp_on_next = 1'b1; state_next = IDLE; end
          8'h0A: begin state_next = READ_PM; rd_idx_next = 8'd0; end
          8'h01: soft_rst = 1'b1;
          8'h00: begin end
          default: begin cmd_err_next = 1'b1; state_next = IDLE; end
        endcase
      end else begin
        case (state_reg)
          PARAM_CA: begin
            case (byte_cnt_reg)
              2'd0: sc_next = {data_s2_reg[7:0], sc_reg[7:0]};
              2'd1: sc_next = {sc_reg[15:8], data_s2_reg[7:0]};
              2'd2: ec_next = {data_s2_reg[7:0], ec_reg[7:0]};
              default: begin ec_next = {ec_reg[15:8], data_s2_reg[7:0]}; state_next = IDLE; end
            endcase
            byte_cnt_next = byte_cnt_reg + 2'd1;
          end
          PARAM_PA: begin
            case (byte_cnt_reg)
              2'd0: sp_next = {data_s2_reg[7:0], sp_reg[7:0]};
              2'd1: sp_next = {sp_reg[15:8], data_s2_reg[7:0]};
              2'd2: ep_next = {data_s2_reg[7:0], ep_reg[7:0]};
              default: begin ep_next = {ep_reg[15:8], data_s2_reg[7:0]}; state_next = IDLE; end
            endcase
            byte_cnt_next = byte_cnt_reg + 2'd1;
          end
          MEM_WRITE: begin
            // An inverted window swallows pixels and freezes the pointer
            if (win_ok) begin
              pix_valid_next = (px_reg < 16'(H_RES)) && (py_reg < 16'(V_RES));
              pix_x_next     = px_reg;
              pix_y_next     = py_reg;
              pix_data_next  = data_s2_reg;
              if (px_reg == ec_reg) begin
                px_next = sc_reg;
                py_next = (py_reg == ep_reg) ? sp_reg : py_reg + 16'd1;
              end else begin
                px_next = px_reg + 16'd1;
              end
            end
          end
          default: begin end
        endcase
      end
    end

    // Hardware reset pin overrides anything the write path decided
    if (!rst_s2_reg || soft_rst) begin
      state_next     = IDLE;
      sc_next        = 16'h0000;
      ec_next        = EC_RST;
      sp_next        = 16'h0000;
      ep_next        = EP_RST;
      px_next        = 16'h0000;
      py_next        = 16'h0000;
      byte_cnt_next  = 2'd0;
      rd_idx_next    = 8'd0;
      disp_on_next   = 1'b0;
      pix_valid_next = 1'b0;
      pix_x_next     = 16'h0000;
      pix_y_next     = 16'h0000;
      pix_data_next  = 16'h0000;
      cmd_err_next   = 1'b0;
      oe_next        = 1'b0;
      data_out_next  = 16'h0000;
    end
  end

  assign LCD_DATA_OUT = data_out_reg;
  assign LCD_DATA_OE  = oe_reg;
  assign pix_valid    = pix_valid_reg;
  assign pix_x        = pix_x_reg;
  assign pix_y        = pix_y_reg;
  assign pix_data     = pix_data_reg;
  assign disp_on      = disp_on_reg;
  assign cmd_err      = cmd_err_reg;

endmodule
